// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues pre-IF requests to a 1-cycle
// synchronous instruction SRAM, and skid-buffers the fetched word across decode stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned XLEN = 32;

  logic            fs_valid_q;
  logic [XLEN-1:0] fs_pc_q;
  logic [XLEN-1:0] inst_buf_q;
  logic            buf_valid_q;

  logic            to_fs_valid;
  logic            fs_allowin;
  logic            buf_capture;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] nextpc;

  // Pre-IF request generation; the redirect target is forced word aligned.
  always_comb begin
    to_fs_valid = ~reset;
    seq_pc      = fs_pc_q + XLEN'(4);
    nextpc      = br_taken ? (br_target & ~XLEN'(3)) : seq_pc;
    fs_allowin  = ~fs_valid_q | ds_allowin | br_taken;
    buf_capture = fs_valid_q & ~ds_allowin & ~br_taken & ~buf_valid_q;
  end

  assign inst_sram_en    = to_fs_valid & fs_allowin;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = '0;

  // A redirect squashes the wrong-path instruction in the same cycle.
  assign fs_to_ds_valid = fs_valid_q & ~br_taken;
  assign fs_pc          = fs_pc_q;
  assign fs_inst        = buf_valid_q ? inst_buf_q : inst_sram_rdata;

  // SRAM output is only trusted in the first stall cycle, hence the one-shot capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= RESET_PC - XLEN'(4);
      inst_buf_q  <= '0;
      buf_valid_q <= 1'b0;
    end else if (fs_allowin) begin
      fs_valid_q  <= to_fs_valid;
      if (to_fs_valid) fs_pc_q <= nextpc;
      buf_valid_q <= 1'b0;
    end else if (buf_capture) begin
      inst_buf_q  <= inst_sram_rdata;
      buf_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a behavioural 1-cycle SRAM
// whose contents are a fixed function of the address.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic        corrupt = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Behavioural SRAM; corrupt models garbage on the read port during a stall.
  always @(posedge clk) begin
    if (corrupt)           inst_sram_rdata <= 32'hdeadbeef;
    else if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = '0;
    #3;
    chk("rst_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("rst_en",    32'(inst_sram_en),   32'd0);
    chk("rst_pc",    fs_pc,               32'h1bfffffc);
    chk("rst_we",    32'(inst_sram_we),   32'd0);
    chk("rst_wdata", inst_sram_wdata,     32'd0);
    tick(); tick();
    reset = 1'b0; #1;
    chk("first_en",    32'(inst_sram_en),   32'd1);
    chk("first_addr",  inst_sram_addr,      32'h1c000000);
    chk("first_valid", 32'(fs_to_ds_valid), 32'd0);
    tick();
    chk("s0_valid", 32'(fs_to_ds_valid), 32'd1);
    chk("s0_pc",    fs_pc,               32'h1c000000);
    chk("s0_inst",  fs_inst,             mem(32'h1c000000));
    chk("s0_addr",  inst_sram_addr,      32'h1c000004);
    tick();
    chk("s1_pc",   fs_pc,          32'h1c000004);
    chk("s1_addr", inst_sram_addr, 32'h1c000008);
    tick();
    chk("s2_pc",   fs_pc,   32'h1c000008);
    chk("s2_inst", fs_inst, mem(32'h1c000008));

    // Decode stall for 3 cycles with the SRAM port corrupted after capture.
    ds_allowin = 1'b0; #1;
    chk("stall_en",    32'(inst_sram_en),   32'd0);
    chk("stall_valid", 32'(fs_to_ds_valid), 32'd1);
    tick();
    corrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rdata_bad", inst_sram_rdata, 32'hdeadbeef);
      chk("stall_hold_pc",   fs_pc,           32'h1c000008);
      chk("stall_hold_inst", fs_inst,         mem(32'h1c000008));
      chk("stall_hold_en",   32'(inst_sram_en), 32'd0);
    end
    ds_allowin = 1'b1; corrupt = 1'b0; #1;
    chk("release_addr", inst_sram_addr, 32'h1c00000c);
    chk("release_inst", fs_inst,        mem(32'h1c000008));
    tick();
    chk("post_stall_pc",   fs_pc,   32'h1c00000c);
    chk("post_stall_inst", fs_inst, mem(32'h1c00000c));

    // Asynchronous reset mid-cycle clears without an edge.
    #1 reset = 1'b1; #1;
    chk("async_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("async_en",    32'(inst_sram_en),   32'd0);
    chk("async_pc",    fs_pc,               32'h1bfffffc);
    tick();
    reset = 1'b0; #1;
    chk("restart_addr", inst_sram_addr, 32'h1c000000);
    tick();
    chk("restart_pc",   fs_pc,   32'h1c000000);
    chk("restart_inst", fs_inst, mem(32'h1c000000));
    tick();
    chk("pre_br_pc", fs_pc, 32'h1c000004);

    // Taken branch cancels the wrong-path instruction.
    br_taken = 1'b1; br_target = 32'h1c000100; #1;
    chk("br_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("br_en",    32'(inst_sram_en),   32'd1);
    chk("br_addr",  inst_sram_addr,      32'h1c000100);
    tick();
    br_taken = 1'b0; #1;
    chk("tgt_valid", 32'(fs_to_ds_valid), 32'd1);
    chk("tgt_pc",    fs_pc,               32'h1c000100);
    chk("tgt_inst",  fs_inst,             mem(32'h1c000100));
    chk("tgt_addr",  inst_sram_addr,      32'h1c000104);

    // Branch during a stall with the buffer full; misaligned target.
    ds_allowin = 1'b0;
    tick(); tick();
    chk("buf_inst", fs_inst, mem(32'h1c000100));
    br_taken = 1'b1; br_target = 32'h1c000043; #1;
    chk("bstall_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("bstall_en",    32'(inst_sram_en),   32'd1);
    chk("bstall_addr",  inst_sram_addr,      32'h1c000040);
    tick();
    br_taken = 1'b0; #1;
    chk("bstall_pc",    fs_pc,               32'h1c000040);
    chk("bstall_inst",  fs_inst,             mem(32'h1c000040));
    chk("bstall_vld",   32'(fs_to_ds_valid), 32'd1);
    ds_allowin = 1'b1;

    // PC wraps from the top of the address space.
    br_taken = 1'b1; br_target = 32'hfffffffc;
    tick();
    br_taken = 1'b0; #1;
    chk("wrap_pc",   fs_pc,          32'hfffffffc);
    chk("wrap_inst", fs_inst,        mem(32'hfffffffc));
    chk("wrap_addr", inst_sram_addr, 32'h00000000);
    tick();
    chk("wrap_pc0",   fs_pc,   32'h00000000);
    chk("wrap_inst0", fs_inst, mem(32'h00000000));

    // Redirect while IF is empty right after reset release.
    reset = 1'b1;
    tick();
    reset = 1'b0; br_taken = 1'b1; br_target = 32'h1c000200; #1;
    chk("empty_br_en",    32'(inst_sram_en),   32'd1);
    chk("empty_br_addr",  inst_sram_addr,      32'h1c000200);
    chk("empty_br_valid", 32'(fs_to_ds_valid), 32'd0);
    tick();
    br_taken = 1'b0; #1;
    chk("empty_br_pc",   fs_pc,   32'h1c000200);
    chk("empty_br_inst", fs_inst, mem(32'h1c000200));
    chk("empty_br_vld",  32'(fs_to_ds_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined LoongArch core.
- Sits directly upstream of the decode stage, which it feeds one instruction per cycle.
- Owns the PC and the pre-IF request to the synchronous instruction SRAM (1-cycle read latency).
- Holds the fetched word in a skid buffer while decode stalls, and cancels wrong-path fetches on a taken-branch redirect.

Parameters:
RESET_PC, 32'h1c000000, address of the first fetch after reset release.

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ds_allowin  input  1  decode stage can accept an instruction this cycle
br_taken  input  1  valid-qualified taken-branch redirect from decode (pulse)
br_target  input  32  redirect address, sampled when br_taken=1
fs_to_ds_valid  output  1  fs_pc/fs_inst hold a valid instruction for decode
fs_pc  output  32  PC of the instruction offered to decode
fs_inst  output  32  instruction word offered to decode
inst_sram_en  output  1  SRAM read enable
inst_sram_we  output  1  tied 0
inst_sram_addr  output  32  SRAM read address (word aligned)
inst_sram_wdata  output  32  tied 0
inst_sram_rdata  input  32  SRAM read data, valid the cycle after a request

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. While reset=1:
  - fs_valid=0, buf_valid=0, fs_pc=RESET_PC-4.
  - fs_to_ds_valid=0, inst_sram_en=0.
- Internal state: fs_valid, fs_pc[31:0], inst_buf[31:0], buf_valid.
- Combinational terms:
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc + 32'd4, wrapping modulo 2^32 (0xfffffffc -> 0x00000000).
  - nextpc = br_taken ? {br_target[31:2],2'b00} : seq_pc. Target bits [1:0] are ignored.
  - fs_allowin = ~fs_valid | ds_allowin | br_taken. fs_ready_go is constantly 1.
  - inst_sram_en = to_fs_valid & fs_allowin.
  - inst_sram_addr = nextpc.
  - fs_to_ds_valid = fs_valid & ~br_taken.
  - fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
  - fs_pc output equals the fs_pc register.
- Rising edge, when fs_allowin=1:
  - fs_valid <= to_fs_valid.
  - If to_fs_valid, fs_pc <= nextpc.
  - buf_valid <= 0.
- Rising edge, skid buffer capture: when fs_valid & ~ds_allowin & ~br_taken & ~buf_valid:
  - inst_buf <= inst_sram_rdata, buf_valid <= 1.
  - fs_pc and fs_valid hold.
  - The SRAM output is not relied on after the first stall cycle.
- Latency:
  - First request (addr=RESET_PC) is issued in the first cycle with reset=0.
  - fs_to_ds_valid rises on the next edge.
  - Steady state: one instruction per cycle when ds_allowin=1.
- Stall: while ds_allowin=0 and no branch, no new request (inst_sram_en=0), and all outputs hold stable, buffered word included.
- Branch redirect (br_taken=1 in cycle t):
  - The instruction currently in IF (wrong path) is cancelled: fs_to_ds_valid=0 in cycle t regardless of ds_allowin.
  - The request for br_target is issued in cycle t.
  - The target instruction is offered from cycle t+1.
  - br_taken overrides a decode stall; any buffered word is discarded.
- Branch while IF empty: the redirect still issues; no instruction is lost.
- Reset asserted mid-operation: immediate clear as above; in-flight SRAM data is ignored. Fetch restarts at RESET_PC after release.

Test Plan:
- Reset release, ds_allowin=1 held -> inst_sram_addr sequence 0x1c000000, 0x1c000004, 0x1c000008. fs_to_ds_valid first high one cycle later with fs_pc=0x1c000000 and fs_inst=mem[0x1c000000].
- Stall ds_allowin=0 for 3 cycles while fs_pc=0x1c000008 -> inst_sram_en=0; fs_pc/fs_inst stable; SRAM rdata corrupted to 0xdeadbeef during the stall does not change fs_inst. On release, next addr is 0x1c00000c.
- br_taken=1, br_target=0x1c000100 with fs_pc=0x1c000004 -> fs_to_ds_valid=0 that cycle; addr=0x1c000100; next cycle fs_pc=0x1c000100 with the correct instruction.
- br_taken=1 during a decode stall with the buffer full, br_target=0x1c000043 -> buffer dropped; addr=0x1c000040; the stall does not block the redirect.
- Async reset pulse mid-cycle during stream -> outputs clear without a clock edge; restart fetch at 0x1c000000.
- fs_pc=0xfffffffc, ds_allowin=1 -> next addr 0x00000000.
